// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter that shares the two combinational read ports of the
// register file between NREQ requesters. It latches the winner's addresses,
// captures both read ports one cycle later and returns the data with a
// one-cycle one-hot ack. Each transaction takes IDLE -> READ -> ACK.
//
// Handshake: a requester raises req[i] (level) with its addresses and holds it
// until it sees ack[i]. req is sampled only in IDLE. Addresses are latched at
// the grant edge and later address changes are ignored. The ack pulse is
// issued even if req[i] was dropped after the grant. Data and rd_id hold until
// the next capture.
module regfile_read_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] req_a1,
  input  logic [NREQ*AW-1:0] req_a2,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rd1_out,
  output logic [DW-1:0]     rd2_out,
  output logic [2:0]        rd_id,
  output logic              busy,
  output logic [AW-1:0]     rf_a1,
  output logic [AW-1:0]     rf_a2,
  input  logic [DW-1:0]     rf_rd1,
  input  logic [DW-1:0]     rf_rd2,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [2:0]      last_grant;
  logic [2:0]      grant;
  logic            grant_vld;
  logic [2:0]      hi_idx;
  logic            hi_vld;
  logic [2:0]      lo_idx;
  logic [AW-1:0]   sel_a1;
  logic [AW-1:0]   sel_a2;
  logic [NREQ-1:0] id_onehot;
  logic            load_grant;
  logic            load_data;

  // Round-robin pick: lowest requester above last_grant, else wrap to the
  // lowest requester overall (the first one after wrapping).
  always_comb begin
    hi_idx    = '0;
    hi_vld    = 1'b0;
    lo_idx    = '0;
    grant_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (3'(i) > last_grant)) begin
        hi_vld = 1'b1;
        hi_idx = 3'(i);
      end
      if (req[i]) begin
        grant_vld = 1'b1;
        lo_idx    = 3'(i);
      end
    end
    grant = hi_vld ? hi_idx : lo_idx;
  end

  // Select the winner's address pair and decode rd_id into the ack pattern.
  always_comb begin
    sel_a1    = '0;
    sel_a2    = '0;
    id_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == 3'(i)) begin
        sel_a1 = req_a1[i*AW +: AW];
        sel_a2 = req_a2[i*AW +: AW];
      end
      id_onehot[i] = (rd_id == 3'(i));
    end
  end

  // Next-state and datapath load strobes; arbitration only happens in IDLE.
  always_comb begin
    state_nx   = state;
    load_grant = 1'b0;
    load_data  = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nx   = READ;
          load_grant = 1'b1;
        end
      end
      READ: begin
        state_nx  = ACK;
        load_data = 1'b1;
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Address latch at grant, data capture plus ack pulse out of READ.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack        <= '0;
      rd1_out    <= '0;
      rd2_out    <= '0;
      rd_id      <= '0;
      rf_a1      <= '0;
      rf_a2      <= '0;
      last_grant <= 3'(NREQ - 1);
    end else begin
      ack <= '0;
      if (load_grant) begin
        rf_a1      <= sel_a1;
        rf_a2      <= sel_a2;
        rd_id      <= grant;
        last_grant <= grant;
      end
      if (load_data) begin
        rd1_out <= rf_rd1;
        rd2_out <= rf_rd2;
        ack     <= id_onehot;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter: a vector table of single
// arbitrations from IDLE plus hand-written multi-cycle sequences.
module tb_regfile_read_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req;
  logic [14:0] req_a1;
  logic [14:0] req_a2;
  logic [2:0]  ack;
  logic [31:0] rd1_out;
  logic [31:0] rd2_out;
  logic [2:0]  rd_id;
  logic        busy;
  logic [4:0]  rf_a1;
  logic [4:0]  rf_a2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic [1:0]  state_dbg;

  int errors;
  int checks;

  regfile_read_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_a1    (req_a1),
    .req_a2    (req_a2),
    .ack       (ack),
    .rd1_out   (rd1_out),
    .rd2_out   (rd2_out),
    .rd_id     (rd_id),
    .busy      (busy),
    .rf_a1     (rf_a1),
    .rf_a2     (rf_a2),
    .rf_rd1    (rf_rd1),
    .rf_rd2    (rf_rd2),
    .state_dbg (state_dbg)
  );

  // Register file model: reg[i] = 32'h1000_0000 + i.
  assign rf_rd1 = 32'h1000_0000 + {27'd0, rf_a1};
  assign rf_rd2 = 32'h1000_0000 + {27'd0, rf_a2};

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  req;
    logic [14:0] a1;
    logic [14:0] a2;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [2:0]  ack;
    logic [2:0]  id;
  } vec_t;

  vec_t vecs[8];

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transaction starting in IDLE with req already driven.
  task automatic txn(input string nm, input logic [2:0] exp_ack, input logic [2:0] exp_id,
                     input logic [4:0] ra1, input logic [4:0] ra2, input logic [2:0] drop);
    logic [31:0] d1;
    logic [31:0] d2;
    d1 = 32'h1000_0000 + {27'd0, ra1};
    d2 = 32'h1000_0000 + {27'd0, ra2};
    tick();
    chk({nm, "_busy_read"}, {31'd0, busy}, 32'd1);
    chk({nm, "_rf_a1"}, {27'd0, rf_a1}, {27'd0, ra1});
    chk({nm, "_rf_a2"}, {27'd0, rf_a2}, {27'd0, ra2});
    chk({nm, "_ack_read"}, {29'd0, ack}, 32'd0);
    tick();
    chk({nm, "_ack"}, {29'd0, ack}, {29'd0, exp_ack});
    chk({nm, "_rd1"}, rd1_out, d1);
    chk({nm, "_rd2"}, rd2_out, d2);
    chk({nm, "_rd_id"}, {29'd0, rd_id}, {29'd0, exp_id});
    req = req & ~drop;
    tick();
    chk({nm, "_ack_off"}, {29'd0, ack}, 32'd0);
    chk({nm, "_busy_idle"}, {31'd0, busy}, 32'd0);
    chk({nm, "_rd1_hold"}, rd1_out, d1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    // Requester addresses packed {r2, r1, r0}.
    vecs[0] = '{3'b010, {5'd0, 5'd5, 5'd0},    {5'd0, 5'd9, 5'd0},    5'd5,  5'd9,  3'b010, 3'd1};
    vecs[1] = '{3'b100, {5'd31, 5'd0, 5'd0},   {5'd0, 5'd0, 5'd0},    5'd31, 5'd0,  3'b100, 3'd2};
    vecs[2] = '{3'b001, {5'd0, 5'd0, 5'd12},   {5'd0, 5'd0, 5'd12},   5'd12, 5'd12, 3'b001, 3'd0};
    vecs[3] = '{3'b111, {5'd6, 5'd3, 5'd1},    {5'd8, 5'd4, 5'd2},    5'd3,  5'd4,  3'b010, 3'd1};
    vecs[4] = '{3'b101, {5'd20, 5'd0, 5'd7},   {5'd21, 5'd0, 5'd17},  5'd20, 5'd21, 3'b100, 3'd2};
    vecs[5] = '{3'b011, {5'd0, 5'd13, 5'd10},  {5'd0, 5'd14, 5'd11},  5'd10, 5'd11, 3'b001, 3'd0};
    vecs[6] = '{3'b101, {5'd20, 5'd0, 5'd7},   {5'd21, 5'd0, 5'd17},  5'd20, 5'd21, 3'b100, 3'd2};
    vecs[7] = '{3'b110, {5'd28, 5'd30, 5'd0},  {5'd27, 5'd29, 5'd0},  5'd30, 5'd29, 3'b010, 3'd1};

    // Reset held with all requests pending: nothing may be acked.
    reset  = 1'b1;
    req    = 3'b111;
    req_a1 = {5'd6, 5'd3, 5'd1};
    req_a2 = {5'd8, 5'd4, 5'd2};
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_ack", {29'd0, ack}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rd1", rd1_out, 32'd0);
      chk("rst_rd2", rd2_out, 32'd0);
      chk("rst_rf_a1", {27'd0, rf_a1}, 32'd0);
    end
    reset = 1'b0;

    // Round robin from reset: 0 first, then 1, then 2, each dropping after ack.
    txn("rr0", 3'b001, 3'd0, 5'd1, 5'd2, 3'b001);
    txn("rr1", 3'b010, 3'd1, 5'd3, 5'd4, 3'b010);
    txn("rr2", 3'b100, 3'd2, 5'd6, 5'd8, 3'b100);
    req = 3'b001;
    txn("rr_lone0", 3'b001, 3'd0, 5'd1, 5'd2, 3'b001);

    // Vector table; each vector starts in IDLE and withdraws all requests at ack.
    for (int v = 0; v < 8; v++) begin
      req    = vecs[v].req;
      req_a1 = vecs[v].a1;
      req_a2 = vecs[v].a2;
      txn($sformatf("vec%0d", v), vecs[v].ack, vecs[v].id, vecs[v].ra1, vecs[v].ra2, 3'b111);
    end

    // Lone requester held high is re-granted back to back.
    req_a1 = {5'd6, 5'd3, 5'd1};
    req_a2 = {5'd8, 5'd4, 5'd2};
    req    = 3'b010;
    txn("single0", 3'b010, 3'd1, 5'd3, 5'd4, 3'b000);
    txn("single1", 3'b010, 3'd1, 5'd3, 5'd4, 3'b010);

    // Fairness: req[0] held continuously, req[2] joins; grants alternate.
    req = 3'b001;
    txn("fair0", 3'b001, 3'd0, 5'd1, 5'd2, 3'b000);
    req[2] = 1'b1;
    txn("fair1", 3'b100, 3'd2, 5'd6, 5'd8, 3'b000);
    txn("fair2", 3'b001, 3'd0, 5'd1, 5'd2, 3'b000);
    txn("fair3", 3'b100, 3'd2, 5'd6, 5'd8, 3'b101);

    // Address change during READ must not affect captured data.
    req_a1 = {5'd6, 5'd3, 5'd5};
    req_a2 = {5'd8, 5'd4, 5'd9};
    req    = 3'b001;
    tick();
    chk("achg_rf_a1", {27'd0, rf_a1}, 32'd5);
    req_a1[4:0] = 5'd7;
    tick();
    chk("achg_ack", {29'd0, ack}, 32'h1);
    chk("achg_rd1", rd1_out, 32'h1000_0005);
    chk("achg_rd2", rd2_out, 32'h1000_0009);
    req = 3'b000;
    tick();
    chk("achg_ack_off", {29'd0, ack}, 32'd0);

    // Reset during READ aborts the transaction; held req is served afterwards.
    req_a1 = {5'd6, 5'd3, 5'd1};
    req_a2 = {5'd8, 5'd4, 5'd2};
    req    = 3'b010;
    tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_rf_a1", {27'd0, rf_a1}, 32'd3);
    reset = 1'b1;
    tick();
    chk("mid_ack", {29'd0, ack}, 32'd0);
    chk("mid_rd1", rd1_out, 32'd0);
    chk("mid_rd2", rd2_out, 32'd0);
    chk("mid_rd_id", {29'd0, rd_id}, 32'd0);
    chk("mid_state", {30'd0, state_dbg}, 32'd0);
    chk("mid_busy_rst", {31'd0, busy}, 32'd0);
    chk("mid_rf_a1_rst", {27'd0, rf_a1}, 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_regrant_a1", {27'd0, rf_a1}, 32'd3);
    tick();
    chk("mid_reack", {29'd0, ack}, 32'h2);
    chk("mid_rerd1", rd1_out, 32'h1000_0003);
    chk("mid_reid", {29'd0, rd_id}, 32'd1);
    req = 3'b000;
    tick();
    chk("mid_reack_off", {29'd0, ack}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
- Shares the two combinational read ports (A1/RD1, A2/RD2) of the 32x32 register file between NREQ requesters, e.g. decode, debug monitor and exception unit.
- Round-robin arbitration with a per-requester req/ack handshake.
- The winner's addresses are latched, both ports are read, and the data is returned registered with a one-cycle ack pulse.
- Sits between the requesters and the register file. The register file stays purely combinational.

Parameters:
- NREQ, 3, number of requesters (2..8).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester read request, level.
- req_a1  in  NREQ*AW  packed first-port addresses; requester i uses bits [i*AW +: AW].
- req_a2  in  NREQ*AW  packed second-port addresses, same packing.
- ack  out  NREQ  one-hot, one-cycle pulse: data for requester i is valid.
- rd1_out  out  DW  captured register value for the first address.
- rd2_out  out  DW  captured register value for the second address.
- rd_id  out  3  index of the requester the current/last data belongs to.
- busy  out  1  high while not in IDLE.
- rf_a1  out  AW  registered address to register file A1.
- rf_a2  out  AW  registered address to register file A2.
- rf_rd1  in  DW  register file RD1.
- rf_rd2  in  DW  register file RD2.

Behaviour:
- Reset (synchronous, on clk while reset=1):
  - state=IDLE; ack=0; rd1_out=rd2_out=0; rd_id=0; rf_a1=rf_a2=0; busy=0.
  - last_grant=NREQ-1, so requester 0 has top priority on the first arbitration.
- FSM states: IDLE, READ, ACK.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick winner g = the first set req bit searching from last_grant+1 upward, wrapping modulo NREQ.
  - On the clock edge: rf_a1 <= req_a1[g], rf_a2 <= req_a2[g], rd_id <= g, last_grant <= g, state <= READ.
- READ:
  - rf_rd1/rf_rd2 are valid combinationally from the registered addresses.
  - On the clock edge: rd1_out <= rf_rd1, rd2_out <= rf_rd2, ack <= onehot(rd_id), state <= ACK.
- ACK:
  - ack is high for exactly this cycle.
  - On the clock edge: ack <= 0, state <= IDLE. No arbitration happens in ACK.
- Latency and throughput:
  - req sampled high in IDLE at cycle t gives ack and data in cycle t+2.
  - At most one transaction per 3 cycles.
- Data hold: rd1_out, rd2_out and rd_id hold their values after ack until the next READ capture.
- busy = (state != IDLE).
- Handshake rules:
  - A requester holds req high until it sees its ack bit. It must drop req in the ack cycle unless it wants another read.
  - req is sampled only in IDLE. A req still high in the ack cycle is treated as a new request at the next IDLE.
  - Addresses are latched at grant. Address changes after the grant edge do not affect the transaction.
  - A requester that drops req after the grant still receives its ack pulse; the arbiter ignores that it was dropped.
- Fairness: a requester holding req continuously is granted within NREQ transactions (3*NREQ cycles) of first being sampled.
- Simultaneous requests: exactly one grant per arbitration, chosen by the round-robin order above. Losers stay pending with no ack.
- Single requester: it is re-granted back-to-back every 3 cycles; round-robin never blocks a lone requester.
- Address aliasing: rf_a1==rf_a2 is legal; both outputs return the same register.
- Reset mid-operation:
  - In READ or ACK, reset aborts: no ack is issued on the next cycle and all outputs return to reset values.
  - The pending requester must re-request.
- rd_id is zero-extended when NREQ < 8.

Test Plan:
- Bench register file loaded with reg[i]=32'h1000_0000+i.
- Reset then idle: reset=1 for 2 cycles with req=3'b111 → ack=0, busy=0, rd1_out=rd2_out=0 throughout; after release, the first grant goes to requester 0.
- Single read: req=3'b010, a1=5, a2=9 at cycle t → rf_a1=5, rf_a2=9 at t+1; ack=3'b010, rd1_out=32'h1000_0005, rd2_out=32'h1000_0009, rd_id=1 at t+2; ack=0 at t+3.
- Round-robin: req=3'b111 held, each requester dropping its req after its own ack → acks in order 3'b001, 3'b010, 3'b100, spaced 3 cycles apart. Then requester 0 alone → granted next.
- Fairness: req[0] held high continuously and req[2] raised → req[2] acked no later than the second transaction after it is sampled; acks alternate 0,2,0,2.
- Address change after grant: a1 changes 5→7 in the READ cycle → rd1_out=32'h1000_0005.
- Reset mid-op: reset asserted in the READ cycle → no ack pulse, rd1_out=0, state IDLE; with req still high, a new transaction completes 2 cycles after reset drops.
